// File: rtl/cpu_program_loader_if.sv
// Stream-in handshake plus the two external memory ports driven by the program loader.
// master = loader side, slave = host/stream source and memories.
interface cpu_program_loader_if #(
   parameter int ADDR_W = 64
);
   logic              s_valid;
   logic [31:0]       s_data;
   logic              s_ready;

   logic [ADDR_W-1:0] addr_ext;
   logic              wen_ext;
   logic              ren_ext;
   logic [31:0]       wdata_ext;
   logic [31:0]       rdata_ext;

   logic [ADDR_W-1:0] addr_ext_2;
   logic              wen_ext_2;
   logic              ren_ext_2;
   logic [63:0]       wdata_ext_2;
   logic [63:0]       rdata_ext_2;

   modport master (
      input  s_valid, s_data, rdata_ext, rdata_ext_2,
      output s_ready,
      output addr_ext, wen_ext, ren_ext, wdata_ext,
      output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
   );

   modport slave (
      output s_valid, s_data, rdata_ext, rdata_ext_2,
      input  s_ready,
      input  addr_ext, wen_ext, ren_ext, wdata_ext,
      input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
   );
endinterface

// File: rtl/cpu_program_loader.sv
// Boot loader: parses header-framed 32-bit words into imem (32-bit) / dmem (64-bit) writes, then enables the core.
// Optional macro LOADER_READBACK_EN: every write is read back and compared before the next word is taken.
module cpu_program_loader #(
   parameter int CNT_W  = 14,
   parameter int ADDR_W = 64
) (
   input  logic                 clk,
   input  logic                 arst,
   cpu_program_loader_if.master bus,
   output logic                 cpu_enable,
   output logic                 load_done,
   output logic                 load_error
);
   typedef enum logic [3:0] {
      S_HDR,
      S_IMEM,
      S_DMEM_LO,
      S_DMEM_HI,
      S_DRAIN,
      S_DONE,
      S_ERROR,
      S_WAIT_WR,
      S_VERIFY_RD,
      S_VERIFY_CMP
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   state_t            eff_state;
   state_t            after_write;
   state_t            data_state;

   logic [ADDR_W-1:0] addr_cnt_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              last_reg;
   logic              tgt_reg;
   logic [31:0]       lo_reg;

   logic [ADDR_W-1:0] addr_reg;
   logic [31:0]       wdata_reg;
   logic              wen_reg;
   logic [ADDR_W-1:0] addr2_reg;
   logic [63:0]       wdata2_reg;
   logic              wen2_reg;

   logic              xfer;
   logic              hdr_bad;
   logic [CNT_W-1:0]  hdr_cnt;
   logic [ADDR_W-1:0] hdr_addr;

   assign hdr_cnt    = bus.s_data[16 +: CNT_W];
   assign hdr_addr   = {{(ADDR_W-16){1'b0}}, bus.s_data[15:0]};
   assign hdr_bad    = (hdr_cnt == '0) ||
                       (bus.s_data[30] ? (bus.s_data[2:0] != 3'd0) : (bus.s_data[1:0] != 2'd0));
   assign xfer       = bus.s_valid && bus.s_ready;
   assign data_state = tgt_reg ? S_DMEM_LO : S_IMEM;

`ifdef LOADER_READBACK_EN
   logic verify_ok;
   assign verify_ok   = tgt_reg ? (bus.rdata_ext_2 == wdata2_reg) : (bus.rdata_ext == wdata_reg);
   assign after_write = S_WAIT_WR;

   // The compare cycle behaves like whichever state follows it, so a word can be taken
   // in the same cycle the read data checks out (3 cycles per imem word).
   always_comb begin
      eff_state = state_reg;
      if (state_reg == S_VERIFY_CMP) begin
         if (!verify_ok) begin
            eff_state = S_ERROR;
         end else if (cnt_reg != '0) begin
            eff_state = data_state;
         end else begin
            eff_state = last_reg ? S_DONE : S_HDR;
         end
      end
   end
`else
   logic unused_rdata;
   assign unused_rdata = ^{bus.rdata_ext, bus.rdata_ext_2};
   assign eff_state    = state_reg;
   // Final write of a last segment drains through S_DRAIN so DONE follows the strobe.
   assign after_write  = (cnt_reg == CNT_W'(1)) ? (last_reg ? S_DRAIN : S_HDR) : data_state;
`endif

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_reg <= S_HDR;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = eff_state;
      case (eff_state)
         S_HDR: begin
            if (xfer) begin
               if (hdr_bad) begin
                  state_next = S_ERROR;
               end else begin
                  state_next = bus.s_data[30] ? S_DMEM_LO : S_IMEM;
               end
            end
         end
         S_IMEM, S_DMEM_HI: begin
            if (xfer) begin
               state_next = after_write;
            end
         end
         S_DMEM_LO: begin
            if (xfer) begin
               state_next = S_DMEM_HI;
            end
         end
         S_DRAIN:     state_next = S_DONE;
         S_WAIT_WR:   state_next = S_VERIFY_RD;
         S_VERIFY_RD: state_next = S_VERIFY_CMP;
         default:     state_next = eff_state;
      endcase
   end

   always_comb begin
      bus.s_ready   = !arst && (eff_state inside {S_HDR, S_IMEM, S_DMEM_LO, S_DMEM_HI});
      bus.ren_ext   = 1'b0;
      bus.ren_ext_2 = 1'b0;
`ifdef LOADER_READBACK_EN
      if (!arst && state_reg == S_VERIFY_RD) begin
         bus.ren_ext   = !tgt_reg;
         bus.ren_ext_2 = tgt_reg;
      end
`endif
      cpu_enable = (state_reg == S_DONE);
      load_done  = (state_reg == S_DONE);
      load_error = (state_reg == S_ERROR);
   end

   assign bus.addr_ext    = addr_reg;
   assign bus.wdata_ext   = wdata_reg;
   assign bus.wen_ext     = wen_reg;
   assign bus.addr_ext_2  = addr2_reg;
   assign bus.wdata_ext_2 = wdata2_reg;
   assign bus.wen_ext_2   = wen2_reg;

   // Address/data registers only change on a write, so they hold while strobes are low.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         addr_cnt_reg <= '0;
         cnt_reg      <= '0;
         last_reg     <= 1'b0;
         tgt_reg      <= 1'b0;
         lo_reg       <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         wen_reg      <= 1'b0;
         addr2_reg    <= '0;
         wdata2_reg   <= '0;
         wen2_reg     <= 1'b0;
      end else begin
         wen_reg  <= 1'b0;
         wen2_reg <= 1'b0;
         if (xfer) begin
            case (eff_state)
               S_HDR: begin
                  addr_cnt_reg <= hdr_addr;
                  cnt_reg      <= hdr_cnt;
                  last_reg     <= bus.s_data[31];
                  tgt_reg      <= bus.s_data[30];
               end
               S_IMEM: begin
                  wen_reg      <= 1'b1;
                  addr_reg     <= addr_cnt_reg;
                  wdata_reg    <= bus.s_data;
                  addr_cnt_reg <= addr_cnt_reg + ADDR_W'(4);
                  cnt_reg      <= cnt_reg - CNT_W'(1);
               end
               S_DMEM_LO: begin
                  lo_reg <= bus.s_data;
               end
               S_DMEM_HI: begin
                  wen2_reg     <= 1'b1;
                  addr2_reg    <= addr_cnt_reg;
                  wdata2_reg   <= {bus.s_data, lo_reg};
                  addr_cnt_reg <= addr_cnt_reg + ADDR_W'(8);
                  cnt_reg      <= cnt_reg - CNT_W'(1);
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_cpu_program_loader.sv
// Scoreboard bench for cpu_program_loader: stimulus pushes expected writes, a forked monitor pops and compares.
module tb_cpu_program_loader;
   localparam int ADDR_W = 64;
`ifdef LOADER_READBACK_EN
   localparam int DONE_LAT = 3;
`else
   localparam int DONE_LAT = 1;
`endif

   logic clk  = 1'b0;
   logic arst = 1'b1;
   logic cpu_enable, load_done, load_error;

   cpu_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

   cpu_program_loader #(.CNT_W(14), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .arst       (arst),
      .bus        (bus),
      .cpu_enable (cpu_enable),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        port;
      logic [63:0] addr;
      logic [63:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_tests = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  last_wr_cyc = 0;
   int  done_cyc = 0;
   int  n_writes = 0;

   // Memory model: synchronous write, registered read, optional corruption of the 2nd imem read.
   logic        fault_en = 1'b0;
   logic [7:0]  imem_reads;
   logic [31:0] imem [0:255];
   logic [63:0] dmem [0:255];
   initial begin
      bus.rdata_ext   = '0;
      bus.rdata_ext_2 = '0;
   end
   always @(posedge clk) begin
      if (arst) begin
         imem_reads <= 8'd0;
      end else begin
         if (bus.wen_ext)   imem[bus.addr_ext[9:2]]    <= bus.wdata_ext;
         if (bus.wen_ext_2) dmem[bus.addr_ext_2[10:3]] <= bus.wdata_ext_2;
         if (bus.ren_ext) begin
            bus.rdata_ext <= (fault_en && imem_reads == 8'd1) ? ~imem[bus.addr_ext[9:2]]
                                                              : imem[bus.addr_ext[9:2]];
            imem_reads <= imem_reads + 8'd1;
         end
         if (bus.ren_ext_2) bus.rdata_ext_2 <= dmem[bus.addr_ext_2[10:3]];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end else begin
         $display("[TB] ok %s = %0h", name, act);
      end
   endtask

   task automatic expect_wr(input logic port, input logic [63:0] addr, input logic [63:0] data);
      wr_t e;
      e.port = port;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic check_wr(input logic port, input logic [63:0] addr, input logic [63:0] data);
      wr_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_write: got port=%0d addr=%0h data=%0h, expected no write", port, addr, data);
      end else begin
         e = exp_q.pop_front();
         if (e.port !== port || e.addr !== addr || e.data !== data) begin
            n_fail++;
            $display("FAIL write: got port=%0d addr=%0h data=%0h, expected port=%0d addr=%0h data=%0h",
                     port, addr, data, e.port, e.addr, e.data);
         end else begin
            $display("[TB] write port=%0d addr=%0h data=%0h ok", port, addr, data);
         end
      end
   endtask

   task automatic monitor();
      logic ld_prev = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.wen_ext || bus.wen_ext_2) begin
            n_writes++;
            last_wr_cyc = cyc;
         end
         if (bus.wen_ext)   check_wr(1'b0, bus.addr_ext, {32'h0, bus.wdata_ext});
         if (bus.wen_ext_2) check_wr(1'b1, bus.addr_ext_2, bus.wdata_ext_2);
         if (bus.wen_ext || bus.ren_ext || bus.wen_ext_2 || bus.ren_ext_2) begin
            n_tests++;
            if ((bus.wen_ext && bus.ren_ext) || (bus.wen_ext_2 && bus.ren_ext_2) ||
                load_done || load_error || arst) begin
               n_fail++;
               $display("FAIL strobe_rule: got wen=%b ren=%b wen2=%b ren2=%b done=%b err=%b arst=%b, expected legal strobes",
                        bus.wen_ext, bus.ren_ext, bus.wen_ext_2, bus.ren_ext_2, load_done, load_error, arst);
            end
         end
         if (load_done && !ld_prev) done_cyc = cyc;
         ld_prev = load_done;
      end
   endtask

   task automatic send(input logic [31:0] w);
      int n = 0;
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      while (!bus.s_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus.s_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: got s_ready=0 for word %h, expected 1 within 40 cycles", w);
         bus.s_valid = 1'b0;
      end else begin
         @(posedge clk);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.s_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.s_valid = 1'b0;
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      while (!load_done && n < max) begin
         @(negedge clk);
         n++;
      end
      check("load_done", {63'h0, load_done}, 64'h1);
   endtask

   initial begin
      int w0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      fork
         monitor();
      join_none

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_s_ready",   {63'h0, bus.s_ready},  64'h0);
      check("rst_wen",       {63'h0, bus.wen_ext},  64'h0);
      check("rst_cpu_en",    {63'h0, cpu_enable},   64'h0);
      check("rst_load_done", {63'h0, load_done},    64'h0);
      check("rst_load_err",  {63'h0, load_error},   64'h0);
      @(negedge clk);
      arst = 1'b0;
      @(negedge clk);
      check("hdr_s_ready", {63'h0, bus.s_ready}, 64'h1);

      // IMEM single segment
      expect_wr(1'b0, 64'h0, 64'h0000_0013);
      expect_wr(1'b0, 64'h4, 64'h0010_0093);
      expect_wr(1'b0, 64'h8, 64'h0020_8113);
      send(32'h8003_0000);
      send(32'h0000_0013);
      send(32'h0010_0093);
      send(32'h0020_8113);
      idle(1);
      wait_done(20);
      check("done_latency", 64'(done_cyc - last_wr_cyc), 64'(DONE_LAT));
      check("t1_cpu_en",  {63'h0, cpu_enable},  64'h1);
      check("t1_s_ready", {63'h0, bus.s_ready}, 64'h0);
      idle(3);
      check("t1_q_empty", 64'(exp_q.size()), 64'h0);

      // DMEM segment then last IMEM segment
      do_reset();
      expect_wr(1'b1, 64'h10, 64'h0123_4567_DEAD_BEEF);
      expect_wr(1'b0, 64'h0,  64'h0050_0513);
      send(32'h4001_0010);
      send(32'hDEAD_BEEF);
      send(32'h0123_4567);
      send(32'h8001_0000);
      send(32'h0050_0513);
      idle(1);
      wait_done(20);
      check("t2_cpu_en",  {63'h0, cpu_enable}, 64'h1);
      check("t2_q_empty", 64'(exp_q.size()), 64'h0);

      // IMEM 8 words with gaps in s_valid
      do_reset();
      w0 = n_writes;
      send(32'h8008_0000);
      for (int i = 0; i < 8; i++) begin
         expect_wr(1'b0, 64'(i * 4), 64'(32'hA000 + i));
         send(32'hA000 + i);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(1);
      wait_done(40);
      idle(2);
      check("t3_write_count", 64'(n_writes - w0), 64'd8);
      check("t3_q_empty", 64'(exp_q.size()), 64'h0);

      // N = 0 header
      do_reset();
      send(32'h8000_0000);
      idle(2);
      check("n0_error",   {63'h0, load_error},  64'h1);
      check("n0_s_ready", {63'h0, bus.s_ready}, 64'h0);
      check("n0_cpu_en",  {63'h0, cpu_enable},  64'h0);

      // Misaligned DMEM start
      do_reset();
      send(32'h4001_0004);
      idle(2);
      check("mis_error",   {63'h0, load_error},  64'h1);
      check("mis_s_ready", {63'h0, bus.s_ready}, 64'h0);
      check("mis_done",    {63'h0, load_done},   64'h0);

      // Reset between DMEM low and high words
      do_reset();
      send(32'h4001_0008);
      send(32'hAAAA_5555);
      idle(1);
      arst = 1'b1;
      @(negedge clk);
      check("midrst_s_ready", {63'h0, bus.s_ready}, 64'h0);
      check("midrst_wen2",    {63'h0, bus.wen_ext_2}, 64'h0);
      arst = 1'b0;
      idle(2);
      expect_wr(1'b1, 64'h8, 64'h2222_2222_1111_1111);
      send(32'hC001_0008);
      send(32'h1111_1111);
      send(32'h2222_2222);
      idle(1);
      wait_done(20);
      check("midrst_q_empty", 64'(exp_q.size()), 64'h0);

`ifdef LOADER_READBACK_EN
      // Second imem read returns corrupted data
      do_reset();
      fault_en = 1'b1;
      w0 = n_writes;
      expect_wr(1'b0, 64'h0, 64'h1111_0001);
      expect_wr(1'b0, 64'h4, 64'h1111_0002);
      send(32'h8003_0000);
      send(32'h1111_0001);
      send(32'h1111_0002);
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h1111_0003;
      repeat (10) @(negedge clk);
      bus.s_valid = 1'b0;
      check("rb_error",       {63'h0, load_error}, 64'h1);
      check("rb_write_count", 64'(n_writes - w0), 64'd2);
      check("rb_q_empty",     64'(exp_q.size()), 64'h0);
      fault_en = 1'b0;
`endif

      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
